wb_protocol_monitor: RTL and testbench

//  Synthesizable Wishbone (classic) bus monitor on the SDRAM controller's host port. It watches
//  the wb_* signals, tracks each transfer with an FSM, and flags rule violations, wait-state

---
 rtl/wb_mon_pkg.sv | 27 ++
 rtl/wb_mon_sat_cnt.sv | 32 +++
 rtl/wb_protocol_monitor.sv | 165 ++++++++++++++++
 tb/tb_wb_protocol_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_mon_pkg.sv
// Shared definitions for the Wishbone classic protocol monitor:
// FSM state encoding, violation bit indices and a saturating helper.
package wb_mon_pkg;

   localparam int NUM_VIOL = 6;

   localparam int R_STB_NO_CYC = 0;
   localparam int R_ACK_NO_REQ = 1;
   localparam int R_UNSTABLE   = 2;
   localparam int R_STB_DROP   = 3;
   localparam int R_TIMEOUT    = 4;
   localparam int R_RST        = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_e;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // 16-bit increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/wb_mon_sat_cnt.sv
// Saturating event counter used for read, write and abort tallies.
// Synchronous clear has priority over increment.
module wb_mon_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: clear, hold at all-ones, or step by one
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // count register
   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone classic monitor: tracks each transfer, flags rule
// violations, counts completed/aborted transfers and the longest ack wait.
module wb_protocol_monitor
   import wb_mon_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [AW-1:0]     wb_addr_i,
   input  logic [DW/8-1:0]   wb_sel_i,
   input  logic [DW-1:0]     wb_dat_i,
   input  logic              wb_ack_o,
   output logic              busy_o,
   output logic              viol_o,
   output logic [5:0]        viol_code_o,
   output logic [5:0]        viol_sticky_o,
   output logic [CNT_W-1:0]  rd_cnt_o,
   output logic [CNT_W-1:0]  wr_cnt_o,
   output logic [CNT_W-1:0]  abort_cnt_o,
   output logic [15:0]       max_wait_o
);

   // wait counter keeps running past TIMEOUT so max_wait reports the
   // true wait of a late ack; the timeout flag fires on the crossing only
   localparam logic [15:0] TO = 16'(TIMEOUT);

   logic [0:0]          state_q, state_d;
   logic [15:0]         wait_q, wait_d;
   logic [15:0]         max_q, max_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                we_q, we_d;
   logic [DW/8-1:0]     sel_q, sel_d;
   logic [DW-1:0]       dat_q, dat_d;
   logic [NUM_VIOL-1:0] viol_d;
   logic [NUM_VIOL-1:0] code_q;
   logic [NUM_VIOL-1:0] sticky_q;
   logic                pulse_q;
   logic                req;
   logic                rd_inc, wr_inc, ab_inc;

   assign req = wb_cyc_i & wb_stb_i;

   // transfer FSM, request latch, wait tracking and rule checks
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      max_d   = max_q;
      addr_d  = addr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      rd_inc  = 1'b0;
      wr_inc  = 1'b0;
      ab_inc  = 1'b0;
      viol_d  = '0;

      viol_d[R_STB_NO_CYC] = wb_stb_i & ~wb_cyc_i;
      viol_d[R_ACK_NO_REQ] = wb_ack_o & ~req;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (wb_ack_o) begin
                  rd_inc = ~wb_we_i;
                  wr_inc = wb_we_i;
               end else begin
                  state_d = ST_WAIT;
                  wait_d  = 16'd1;
                  addr_d  = wb_addr_i;
                  we_d    = wb_we_i;
                  sel_d   = wb_sel_i;
                  dat_d   = wb_dat_i;
                  viol_d[R_TIMEOUT] = (TO == 16'd1);
               end
            end
         end
         ST_WAIT: begin
            if (req && ((wb_addr_i != addr_q) || (wb_we_i != we_q) ||
                        (wb_sel_i != sel_q) ||
                        (we_q && (wb_dat_i != dat_q)))) begin
               viol_d[R_UNSTABLE] = 1'b1;
            end
            if (!wb_cyc_i) begin
               ab_inc  = 1'b1;
               state_d = ST_IDLE;
            end else if (!wb_stb_i) begin
               viol_d[R_STB_DROP] = 1'b1;
               state_d = ST_IDLE;
            end else if (wb_ack_o) begin
               rd_inc  = ~we_q;
               wr_inc  = we_q;
               max_d   = (wait_q > max_q) ? wait_q : max_q;
               state_d = ST_IDLE;
            end else begin
               wait_d = sat_inc16(wait_q);
               viol_d[R_TIMEOUT] = (wait_d == TO) && (wait_q != TO);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and violation registers; reset keeps only the RST sticky bit
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         wait_q   <= '0;
         max_q    <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         dat_q    <= '0;
         code_q   <= '0;
         pulse_q  <= 1'b0;
         sticky_q <= '0;
         sticky_q[R_RST] <= sticky_q[R_RST] | wb_cyc_i | wb_stb_i;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         max_q    <= max_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         dat_q    <= dat_d;
         code_q   <= viol_d;
         pulse_q  <= |viol_d;
         sticky_q <= sticky_q | viol_d;
      end
   end

   wb_mon_sat_cnt #(.W(CNT_W)) u_rd_cnt (
      .clk_i (wb_clk_i),
      .clr_i (wb_rst_i),
      .inc_i (rd_inc),
      .cnt_o (rd_cnt_o)
   );

   wb_mon_sat_cnt #(.W(CNT_W)) u_wr_cnt (
      .clk_i (wb_clk_i),
      .clr_i (wb_rst_i),
      .inc_i (wr_inc),
      .cnt_o (wr_cnt_o)
   );

   wb_mon_sat_cnt #(.W(CNT_W)) u_ab_cnt (
      .clk_i (wb_clk_i),
      .clr_i (wb_rst_i),
      .inc_i (ab_inc),
      .cnt_o (abort_cnt_o)
   );

   assign busy_o        = (state_q == ST_WAIT);
   assign viol_o        = pulse_q;
   assign viol_code_o   = code_q;
   assign viol_sticky_o = sticky_q;
   assign max_wait_o    = max_q;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed bench for wb_protocol_monitor: violation pulses are checked by
// a queue-based scoreboard, counters and flags by directed compares.
module tb_wb_protocol_monitor;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we, ack;
   logic [31:0] addr, dat;
   logic [3:0]  sel;
   logic        busy, viol;
   logic [5:0]  code, sticky;
   logic [CW-1:0] rd_cnt, wr_cnt, ab_cnt;
   logic [15:0] max_wait;

   int n_cmp = 0;
   int n_bad = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   wb_protocol_monitor #(
      .AW(32), .DW(32), .TIMEOUT(256), .CNT_W(CW)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wb_cyc_i      (cyc),
      .wb_stb_i      (stb),
      .wb_we_i       (we),
      .wb_addr_i     (addr),
      .wb_sel_i      (sel),
      .wb_dat_i      (dat),
      .wb_ack_o      (ack),
      .busy_o        (busy),
      .viol_o        (viol),
      .viol_code_o   (code),
      .viol_sticky_o (sticky),
      .rd_cnt_o      (rd_cnt),
      .wr_cnt_o      (wr_cnt),
      .abort_cnt_o   (ab_cnt),
      .max_wait_o    (max_wait)
   );

   // scoreboard: every viol_o pulse must match the next expected code
   always @(negedge clk) begin
      if (!rst && viol === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL viol_unexpected: got code %b, required no pulse",
                     code);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            if (code !== e) begin
               n_bad++;
               $display("FAIL viol_code: got %b, required %b", code, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic c, input logic s, input logic w,
                      input logic [31:0] a, input logic k);
      cyc  = c;
      stb  = s;
      we   = w;
      addr = a;
      ack  = k;
   endtask

   initial begin
      rst = 1'b1;
      sel = 4'hF;
      dat = 32'hDEADBEEF;
      bus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // 1: reset with cyc high
      tick(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_viol", 32'(viol), 32'd0);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_rd", 32'(rd_cnt), 32'd0);
      chk("rst_wr", 32'(wr_cnt), 32'd0);
      chk("rst_abort", 32'(ab_cnt), 32'd0);
      chk("rst_maxwait", 32'(max_wait), 32'd0);
      rst = 1'b0;
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1);
      chk("rst_sticky", 32'(sticky), 32'h20);
      chk("rst_viol_after", 32'(viol), 32'd0);

      // 2: write, four waits then ack
      bus(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
      tick(1);
      chk("wr_busy", 32'(busy), 32'd1);
      tick(3);
      ack = 1'b1;
      tick(1);
      chk("wr_cnt", 32'(wr_cnt), 32'd1);
      chk("wr_maxwait", 32'(max_wait), 32'd4);
      chk("wr_busy_done", 32'(busy), 32'd0);
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1);
      chk("wr_sticky_clean", 32'(sticky[4:0]), 32'd0);

      // 3: read with address change on wait 2
      bus(1'b1, 1'b1, 1'b0, 32'h100, 1'b0);
      tick(2);
      addr = 32'h104;
      exp_q.push_back(6'b000100);
      tick(1);
      addr = 32'h100;
      ack  = 1'b1;
      tick(1);
      chk("unst_rd", 32'(rd_cnt), 32'd1);
      chk("unst_maxwait", 32'(max_wait), 32'd4);
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1);

      // 4: timeout at wait 256, late ack at 300
      bus(1'b1, 1'b1, 1'b0, 32'h200, 1'b0);
      tick(255);
      chk("to_not_early", 32'(sticky[4]), 32'd0);
      exp_q.push_back(6'b010000);
      tick(1);
      chk("to_flag", 32'(sticky[4]), 32'd1);
      chk("to_still_busy", 32'(busy), 32'd1);
      tick(44);
      ack = 1'b1;
      tick(1);
      chk("to_rd", 32'(rd_cnt), 32'd2);
      chk("to_maxwait", 32'(max_wait), 32'd300);
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1);

      // 5: abort at wait 3, then stb drop under cyc
      bus(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
      tick(3);
      bus(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
      tick(1);
      chk("abort_cnt", 32'(ab_cnt), 32'd1);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_noviol", 32'(viol), 32'd0);
      bus(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
      tick(1);
      stb = 1'b0;
      exp_q.push_back(6'b001000);
      tick(1);
      chk("drop_idle", 32'(busy), 32'd0);
      chk("drop_abort", 32'(ab_cnt), 32'd1);
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1);

      // 6: ack and stb without cyc together
      bus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      exp_q.push_back(6'b000011);
      tick(1);
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(2);
      chk("sticky_all", 32'(sticky), 32'h3F);

      // 7: zero-wait reads saturate the read counter
      bus(1'b1, 1'b1, 1'b0, 32'h400, 1'b1);
      tick(20);
      chk("zw_rd_sat", 32'(rd_cnt), 32'hF);
      chk("zw_busy", 32'(busy), 32'd0);
      chk("zw_maxwait", 32'(max_wait), 32'd300);
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(1);

      // 8: reset mid-transfer is not an abort
      bus(1'b1, 1'b1, 1'b0, 32'h500, 1'b0);
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(2);
      chk("mid_rst_abort", 32'(ab_cnt), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sticky", 32'(sticky), 32'h20);

      tick(2);
      chk("pulses_pending", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
